// File: rtl/plic_claim_arbiter.sv
// PLIC per-target priority resolver: sequential one-source-per-cycle scan, threshold compare,
// and claim/complete sequencing against an in-service mask.
module plic_claim_arbiter #(
  parameter int unsigned IRQ_NUM    = 32,
  parameter int unsigned PRIO_WIDTH = 3,
  parameter int unsigned ID_WIDTH   = $clog2(IRQ_NUM)
) (
  input  logic                           pclk,
  input  logic                           prst,
  input  logic [IRQ_NUM-1:0]             ip_i,
  input  logic [IRQ_NUM-1:0]             ie_i,
  input  logic [IRQ_NUM*PRIO_WIDTH-1:0]  prio_i,
  input  logic [PRIO_WIDTH-1:0]          thold_i,
  input  logic                           claim_req_i,
  input  logic                           comp_req_i,
  input  logic [ID_WIDTH-1:0]            comp_id_i,
  output logic [ID_WIDTH-1:0]            claim_id_o,
  output logic [IRQ_NUM-1:0]             claim_clr_o,
  output logic [IRQ_NUM-1:0]             comp_o,
  output logic [ID_WIDTH-1:0]            max_id_o,
  output logic [PRIO_WIDTH-1:0]          max_prio_o,
  output logic                           ext_irq_o,
  output logic [IRQ_NUM-1:0]             busy_mask_o
);

  typedef enum logic [0:0] {StScan, StCommit} state_e;

  localparam logic [ID_WIDTH-1:0] FirstId = ID_WIDTH'(1);
  localparam logic [ID_WIDTH-1:0] LastId  = ID_WIDTH'(IRQ_NUM - 1);

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   idx_q, idx_d;
  logic [ID_WIDTH-1:0]   best_id_q, best_id_d;
  logic [PRIO_WIDTH-1:0] best_prio_q, best_prio_d;
  logic [ID_WIDTH-1:0]   max_id_q, max_id_d;
  logic [PRIO_WIDTH-1:0] max_prio_q, max_prio_d;
  logic [IRQ_NUM-1:0]    busy_q, busy_d;
  logic [IRQ_NUM-1:0]    comp_q, comp_d;

  logic                  cur_ip, cur_ie, cur_busy, eligible;
  logic [PRIO_WIDTH-1:0] cur_prio;
  logic [IRQ_NUM-1:0]    max_hot, comp_hot;
  logic                  claim_fire, comp_fire;

  // Decoders run only over legal slots, so slot 0 and IDs >= IRQ_NUM never decode.
  always_comb begin
    cur_ip   = 1'b0;
    cur_ie   = 1'b0;
    cur_busy = 1'b0;
    cur_prio = '0;
    max_hot  = '0;
    comp_hot = '0;
    for (int unsigned i = 1; i < IRQ_NUM; i++) begin
      if (idx_q == ID_WIDTH'(i)) begin
        cur_ip   = ip_i[i];
        cur_ie   = ie_i[i];
        cur_busy = busy_q[i];
        cur_prio = prio_i[i*PRIO_WIDTH +: PRIO_WIDTH];
      end
      max_hot[i]  = (max_id_q == ID_WIDTH'(i));
      comp_hot[i] = (comp_id_i == ID_WIDTH'(i));
    end
  end

  assign eligible   = cur_ip & cur_ie & ~cur_busy & (cur_prio != '0);
  assign claim_fire = claim_req_i & (max_id_q != '0);
  // Uses the pre-cycle busy mask, so completing the ID being claimed is ignored.
  assign comp_fire  = comp_req_i & |(comp_hot & busy_q);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    best_id_d   = best_id_q;
    best_prio_d = best_prio_q;
    max_id_d    = max_id_q;
    max_prio_d  = max_prio_q;
    busy_d      = busy_q;
    comp_d      = '0;

    if (claim_fire) begin
      busy_d      = busy_q | max_hot;
      max_id_d    = '0;
      max_prio_d  = '0;
      best_id_d   = '0;
      best_prio_d = '0;
      idx_d       = FirstId;
      state_d     = StScan;
    end else begin
      unique case (state_q)
        StScan: begin
          if (eligible && (cur_prio > best_prio_q)) begin
            best_id_d   = idx_q;
            best_prio_d = cur_prio;
          end
          if (idx_q == LastId) begin
            state_d = StCommit;
          end else begin
            idx_d = idx_q + FirstId;
          end
        end
        StCommit: begin
          max_id_d    = best_id_q;
          max_prio_d  = best_prio_q;
          best_id_d   = '0;
          best_prio_d = '0;
          idx_d       = FirstId;
          state_d     = StScan;
        end
        default: state_d = StScan;
      endcase
    end

    if (comp_fire) begin
      busy_d = busy_d & ~comp_hot;
      comp_d = comp_hot;
    end
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q     <= StScan;
      idx_q       <= FirstId;
      best_id_q   <= '0;
      best_prio_q <= '0;
      max_id_q    <= '0;
      max_prio_q  <= '0;
      busy_q      <= '0;
      comp_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      best_id_q   <= best_id_d;
      best_prio_q <= best_prio_d;
      max_id_q    <= max_id_d;
      max_prio_q  <= max_prio_d;
      busy_q      <= busy_d;
      comp_q      <= comp_d;
    end
  end

  assign claim_id_o  = max_id_q;
  assign claim_clr_o = claim_fire ? max_hot : '0;
  assign comp_o      = comp_q;
  assign max_id_o    = max_id_q;
  assign max_prio_o  = max_prio_q;
  assign ext_irq_o   = (max_id_q != '0) && (max_prio_q > thold_i);
  assign busy_mask_o = busy_q;

endmodule

// File: tb/tb_plic_claim_arbiter.sv
// Self-checking bench for plic_claim_arbiter (IRQ_NUM=8): vector table, directed claim/complete
// sequences and randomized transactions against a winner-by-max-priority model.
module tb_plic_claim_arbiter;

  localparam int N  = 8;
  localparam int PW = 3;
  localparam int IW = 3;

  logic              pclk = 1'b0;
  logic              prst;
  logic [N-1:0]      ip_i, ie_i;
  logic [N*PW-1:0]   prio_i;
  logic [PW-1:0]     thold_i;
  logic              claim_req_i, comp_req_i;
  logic [IW-1:0]     comp_id_i;
  logic [IW-1:0]     claim_id_o, max_id_o;
  logic [N-1:0]      claim_clr_o, comp_o, busy_mask_o;
  logic [PW-1:0]     max_prio_o;
  logic              ext_irq_o;

  plic_claim_arbiter #(
    .IRQ_NUM   (N),
    .PRIO_WIDTH(PW)
  ) dut (
    .pclk       (pclk),
    .prst       (prst),
    .ip_i       (ip_i),
    .ie_i       (ie_i),
    .prio_i     (prio_i),
    .thold_i    (thold_i),
    .claim_req_i(claim_req_i),
    .comp_req_i (comp_req_i),
    .comp_id_i  (comp_id_i),
    .claim_id_o (claim_id_o),
    .claim_clr_o(claim_clr_o),
    .comp_o     (comp_o),
    .max_id_o   (max_id_o),
    .max_prio_o (max_prio_o),
    .ext_irq_o  (ext_irq_o),
    .busy_mask_o(busy_mask_o)
  );

  always #5 pclk = ~pclk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [N-1:0]    ip;
    logic [N-1:0]    ie;
    logic [N*PW-1:0] prio;
    logic [PW-1:0]   thold;
    int              id;
    int              p;
    bit              irq;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) step();
  endtask

  task automatic drive(input logic [N-1:0] ip, input logic [N-1:0] ie,
                       input logic [N*PW-1:0] prio, input logic [PW-1:0] thold);
    ip_i    = ip;
    ie_i    = ie;
    prio_i  = prio;
    thold_i = thold;
  endtask

  function automatic logic [N*PW-1:0] pr(input int i, input int v);
    logic [N*PW-1:0] r;
    r = '0;
    r[i*PW +: PW] = v[PW-1:0];
    return r;
  endfunction

  // Winner = highest priority among eligible sources; ties go to the smallest ID.
  function automatic void model_winner(input logic [N-1:0] ip, input logic [N-1:0] ie,
                                       input logic [N-1:0] busy, input logic [N*PW-1:0] prio,
                                       output int id, output int p);
    int pv;
    id = 0;
    p  = 0;
    for (int i = 1; i < N; i++) begin
      pv = int'(prio[i*PW +: PW]);
      if (ip[i] && ie[i] && !busy[i] && pv > p) p = pv;
    end
    if (p != 0) begin
      for (int i = N - 1; i >= 1; i--) begin
        pv = int'(prio[i*PW +: PW]);
        if (ip[i] && ie[i] && !busy[i] && pv == p) id = i;
      end
    end
  endfunction

  logic [N-1:0] mbusy;
  logic [N-1:0] exp_clr, exp_pulse;
  int           eid, ep, act, cid;
  bit           do_claim, do_comp;

  initial begin
    vecs[0] = '{ip: 8'h06, ie: 8'hFF, prio: pr(1, 2) | pr(2, 5), thold: 3'd0,
                id: 2, p: 5, irq: 1'b1};
    vecs[1] = '{ip: 8'h28, ie: 8'hFF, prio: pr(3, 4) | pr(5, 4), thold: 3'd0,
                id: 3, p: 4, irq: 1'b1};
    vecs[2] = '{ip: 8'h28, ie: 8'hFF, prio: pr(3, 4) | pr(5, 4), thold: 3'd4,
                id: 3, p: 4, irq: 1'b0};
    vecs[3] = '{ip: 8'hFF, ie: 8'h00, prio: 24'hFFFFFF, thold: 3'd0,
                id: 0, p: 0, irq: 1'b0};
    vecs[4] = '{ip: 8'h81, ie: 8'hFF, prio: pr(0, 7) | pr(7, 1), thold: 3'd0,
                id: 7, p: 1, irq: 1'b1};
    vecs[5] = '{ip: 8'hFE, ie: 8'hFE, prio: 24'hFFFFF8, thold: 3'd7,
                id: 1, p: 7, irq: 1'b0};
    vecs[6] = '{ip: 8'h0E, ie: 8'h0E, prio: pr(4, 7), thold: 3'd0,
                id: 0, p: 0, irq: 1'b0};
    vecs[7] = '{ip: 8'h60, ie: 8'h40, prio: pr(5, 7) | pr(6, 3), thold: 3'd2,
                id: 6, p: 3, irq: 1'b1};

    prst        = 1'b1;
    claim_req_i = 1'b0;
    comp_req_i  = 1'b0;
    comp_id_i   = '0;
    drive('0, '0, '0, '0);
    cycles(2);
    check("rst_max_id", max_id_o, 0);
    check("rst_max_prio", max_prio_o, 0);
    check("rst_ext_irq", ext_irq_o, 0);
    check("rst_busy", busy_mask_o, 0);
    check("rst_comp", comp_o, 0);
    check("rst_claim_id", claim_id_o, 0);
    prst = 1'b0;
    cycles(N - 1);
    check("first_sweep_quiet", max_id_o, 0);

    for (int v = 0; v < 8; v++) begin
      drive(vecs[v].ip, vecs[v].ie, vecs[v].prio, vecs[v].thold);
      cycles(2 * N);
      check($sformatf("vec%0d_max_id", v), max_id_o, vecs[v].id);
      check($sformatf("vec%0d_max_prio", v), max_prio_o, vecs[v].p);
      check($sformatf("vec%0d_ext_irq", v), ext_irq_o, vecs[v].irq);
    end

    // Threshold acts combinationally.
    drive(8'h28, 8'hFF, pr(3, 4) | pr(5, 4), 3'd0);
    cycles(2 * N);
    check("tie_max_id", max_id_o, 3);
    thold_i = 3'd4;
    #1;
    check("thold_eq_no_irq", ext_irq_o, 0);
    thold_i = 3'd3;
    #1;
    check("thold_below_irq", ext_irq_o, 1);

    // Claim, then the next commit skips the in-service source.
    drive(8'h06, 8'hFF, pr(1, 2) | pr(2, 5), 3'd0);
    cycles(2 * N);
    check("pre_claim_max", max_id_o, 2);
    claim_req_i = 1'b1;
    #1;
    check("claim_id", claim_id_o, 2);
    check("claim_clr", claim_clr_o, 8'h04);
    step();
    claim_req_i = 1'b0;
    check("claim_busy", busy_mask_o, 8'h04);
    check("claim_max_clr", max_id_o, 0);
    check("claim_irq_drop", ext_irq_o, 0);
    claim_req_i = 1'b1;
    #1;
    check("b2b_claim_id", claim_id_o, 0);
    check("b2b_claim_clr", claim_clr_o, 0);
    step();
    claim_req_i = 1'b0;
    check("b2b_busy", busy_mask_o, 8'h04);
    cycles(2 * N);
    check("skip_busy_id", max_id_o, 1);
    check("skip_busy_prio", max_prio_o, 2);

    // Complete: single-cycle pulse, then ignored repeats and ID 0.
    comp_req_i = 1'b1;
    comp_id_i  = 3'd2;
    step();
    comp_req_i = 1'b0;
    check("comp_pulse", comp_o, 8'h04);
    check("comp_busy_clr", busy_mask_o, 8'h00);
    step();
    check("comp_pulse_end", comp_o, 8'h00);
    comp_req_i = 1'b1;
    step();
    comp_req_i = 1'b0;
    check("comp_repeat", comp_o, 8'h00);
    comp_req_i = 1'b1;
    comp_id_i  = 3'd0;
    step();
    comp_req_i = 1'b0;
    check("comp_id0", comp_o, 8'h00);

    // Same-cycle claim and complete.
    drive(8'h10, 8'hFF, pr(4, 6), 3'd0);
    cycles(2 * N);
    check("sim_pre_max", max_id_o, 4);
    claim_req_i = 1'b1;
    comp_req_i  = 1'b1;
    comp_id_i   = 3'd4;
    step();
    claim_req_i = 1'b0;
    comp_req_i  = 1'b0;
    check("sim_same_busy", busy_mask_o, 8'h10);
    check("sim_same_comp", comp_o, 8'h00);
    drive(8'h02, 8'hFF, pr(1, 1), 3'd0);
    cycles(2 * N);
    check("sim_max1", max_id_o, 1);
    claim_req_i = 1'b1;
    step();
    claim_req_i = 1'b0;
    check("sim_busy14", busy_mask_o, 8'h12);
    drive(8'h08, 8'hFF, pr(3, 5), 3'd0);
    cycles(2 * N);
    check("sim_max3", max_id_o, 3);
    claim_req_i = 1'b1;
    comp_req_i  = 1'b1;
    comp_id_i   = 3'd1;
    step();
    claim_req_i = 1'b0;
    comp_req_i  = 1'b0;
    check("sim_both_busy", busy_mask_o, 8'h18);
    check("sim_both_comp", comp_o, 8'h02);
    step();
    check("sim_both_comp_end", comp_o, 8'h00);

    // Reset mid-sweep with sources in service.
    drive(8'h20, 8'hFF, pr(5, 3), 3'd0);
    cycles(2 * N);
    check("mid_pre_max", max_id_o, 5);
    cycles(3);
    prst = 1'b1;
    step();
    check("mid_rst_max", max_id_o, 0);
    check("mid_rst_prio", max_prio_o, 0);
    check("mid_rst_irq", ext_irq_o, 0);
    check("mid_rst_busy", busy_mask_o, 0);
    check("mid_rst_comp", comp_o, 0);
    prst = 1'b0;
    cycles(N - 1);
    check("mid_rst_no_early", max_id_o, 0);
    step();
    check("mid_rst_recommit_id", max_id_o, 5);
    check("mid_rst_recommit_prio", max_prio_o, 3);
    check("mid_rst_recommit_irq", ext_irq_o, 1);

    mbusy = '0;
    for (int it = 0; it < 40; it++) begin
      drive(N'($urandom), N'($urandom), (N*PW)'($urandom), PW'($urandom_range(0, 7)));
      cycles(2 * N);
      model_winner(ip_i, ie_i, mbusy, prio_i, eid, ep);
      check($sformatf("rnd%0d_max_id", it), max_id_o, eid);
      check($sformatf("rnd%0d_max_prio", it), max_prio_o, ep);
      check($sformatf("rnd%0d_ext_irq", it), ext_irq_o, (eid != 0) && (ep > int'(thold_i)));
      check($sformatf("rnd%0d_busy", it), busy_mask_o, mbusy);

      act      = $urandom_range(0, 3);
      do_claim = (act == 0) || (act == 2);
      do_comp  = (act == 1) || (act == 2);
      cid      = $urandom_range(0, N - 1);
      exp_clr  = '0;
      if (do_claim && eid != 0) exp_clr[eid] = 1'b1;
      exp_pulse = '0;
      if (do_comp && cid != 0 && mbusy[cid]) exp_pulse[cid] = 1'b1;

      claim_req_i = do_claim;
      comp_req_i  = do_comp;
      comp_id_i   = IW'(cid);
      #1;
      if (do_claim) begin
        check($sformatf("rnd%0d_claim_id", it), claim_id_o, eid);
        check($sformatf("rnd%0d_claim_clr", it), claim_clr_o, exp_clr);
      end
      step();
      claim_req_i = 1'b0;
      comp_req_i  = 1'b0;
      mbusy = (mbusy | exp_clr) & ~exp_pulse;
      check($sformatf("rnd%0d_comp", it), comp_o, exp_pulse);
      check($sformatf("rnd%0d_busy_after", it), busy_mask_o, mbusy);
      if (exp_clr != '0) check($sformatf("rnd%0d_max_cleared", it), max_id_o, 0);
      step();
      check($sformatf("rnd%0d_comp_end", it), comp_o, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/plic_claim_arbiter.md
Name: plic_claim_arbiter

Overview:
- Per-target priority resolver and claim/complete sequencer for the PLIC.
- Scans all interrupt sources sequentially, one source per cycle, and selects the highest-priority pending, enabled, not-in-service source.
- Drives the target's external interrupt line against a threshold.
- Handles claim reads and complete writes: it issues pending-clear pulses to the IP register and completion pulses to the per-source gateways.

Parameters:
- IRQ_NUM, 32, number of source slots; source 0 is reserved and never selected.
- PRIO_WIDTH, 3, width of each source priority and of the threshold.
- ID_WIDTH, $clog2(IRQ_NUM), width of source IDs.

Ports:
- pclk  in  1  clock.
- prst  in  1  synchronous, active-high reset.
- ip_i  in  IRQ_NUM  pending bits; bit 0 ignored.
- ie_i  in  IRQ_NUM  enable bits; bit 0 ignored.
- prio_i  in  IRQ_NUM*PRIO_WIDTH  flattened priorities; source i occupies [i*PRIO_WIDTH +: PRIO_WIDTH].
- thold_i  in  PRIO_WIDTH  target threshold.
- claim_req_i  in  1  one-cycle claim strobe (APB read of claim/complete).
- comp_req_i  in  1  one-cycle complete strobe (APB write of claim/complete).
- comp_id_i  in  ID_WIDTH  ID being completed.
- claim_id_o  out  ID_WIDTH  ID returned to the claim read; combinational, equals max_id_q.
- claim_clr_o  out  IRQ_NUM  one-hot pending-clear; combinational, same cycle as claim_req_i.
- comp_o  out  IRQ_NUM  one-hot registered completion pulse to gateways.
- max_id_o  out  ID_WIDTH  committed winner ID.
- max_prio_o  out  PRIO_WIDTH  committed winner priority.
- ext_irq_o  out  1  external interrupt request to the target.
- busy_mask_o  out  IRQ_NUM  in-service mask (claimed, not yet completed).

Behaviour:
- Reset: all registers clear and scan index is 1. All outputs are 0 and stay 0 until the first sweep commits.
- FSM states: SCAN and COMMIT.
  - SCAN: each cycle visit source idx.
  - A source is eligible iff ip_i[idx] & ie_i[idx] & ~busy_mask_q[idx] & (prio[idx] != 0).
  - If eligible and prio[idx] > best_prio, load best_id/best_prio. The comparison is strict, so on equal priority the lowest ID wins.
  - Inputs are sampled at visit time only; changes to already-visited sources take effect in the next sweep.
  - When idx == IRQ_NUM-1, go to COMMIT after evaluating that source.
  - COMMIT (1 cycle): max_id_q <= best_id, max_prio_q <= best_prio; clear best_*; idx <= 1; return to SCAN.
  - Sweep period is IRQ_NUM cycles, so a newly pending source reaches max_id_o within at most 2*IRQ_NUM cycles.
- ext_irq_o = (max_id_q != 0) && (max_prio_q > thold_i).
  - Combinational in thold_i, so a threshold change takes effect in the same cycle.
  - Priority equal to the threshold does not interrupt.
- Claim (claim_req_i = 1):
  - claim_id_o = max_id_q.
  - If max_id_q != 0:
    - claim_clr_o[max_id_q] = 1;
    - next cycle busy_mask_q[max_id_q] = 1;
    - max_id_q and max_prio_q clear to 0 (ext_irq_o drops the next cycle);
    - best_* clear and idx restarts at 1, in either state. COMMIT is suppressed in that cycle.
  - If max_id_q == 0: returns 0 with no side effects.
- Complete (comp_req_i = 1):
  - If comp_id_i is nonzero and busy_mask_q[comp_id_i] is set, clear the busy bit next cycle and assert comp_o[comp_id_i] for exactly 1 cycle, starting the next cycle.
  - Otherwise (ID 0, out of range, or not in service) ignore silently: no pulse and no state change.
- Simultaneous claim and complete: both are evaluated against the pre-cycle busy_mask_q.
  - Completing an ID that is being claimed in the same cycle is ignored.
  - Completing ID A while claiming ID B applies both updates.
- Back-to-back claims before a new commit return 0.
- IDs >= IRQ_NUM never appear on any output.

Test Plan:
1. Reset with IRQ_NUM=8. Set ip=8'b0000_0110, ie=8'hFF, prio[1]=2, prio[2]=5, thold=0; wait 16 cycles -> max_id_o=2, max_prio_o=5, ext_irq_o=1.
2. Tie: prio[3]=prio[5]=4, both pending and enabled -> max_id_o=3. Raise thold to 4 -> ext_irq_o=0 in the same cycle; set thold=3 -> ext_irq_o=1.
3. Claim with max_id=2 -> claim_id_o=2 and claim_clr_o=8'b0000_0100 in the strobe cycle; next cycle busy_mask_o[2]=1, max_id_o=0, ext_irq_o=0. With ip[2] still set, the next commit selects 1 (prio 2), not 2.
4. Complete comp_id=2 -> comp_o=8'b0000_0100 for exactly one cycle and busy_mask_o[2]=0. Repeat complete id 2 -> no pulse. Complete id 0 -> no pulse.
5. Same-cycle claim (max_id=4) and complete id 4 (not busy) -> complete ignored, busy_mask_o[4]=1, comp_o=0. Separately, claim id 3 and complete busy id 1 in the same cycle -> busy_mask_o bit 3 set, bit 1 cleared, comp_o[1] pulses.
6. Assert prst mid-sweep with a claimed source -> next cycle all outputs 0, busy_mask_o=0, and the scan restarts at idx 1; the previous winner is re-committed within IRQ_NUM cycles of reset release.
